// File: rtl/tisc_pipe_core.sv
// rtl/tisc_pipe_core.sv - five-stage TISC core; TISC_FWD_EN builds EX operand forwarding
// Without TISC_FWD_EN, ID interlocks on any in-flight writer instead of forwarding.
module tisc_pipe_core #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] pc,
  input  logic [15:0]   instr,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          dmem_we,
  input  logic [DW-1:0] dmem_rdata,
  output logic [2:0]    flag,
  output logic          halted
);

  localparam logic [3:0]  OP_ADD    = 4'h0;
  localparam logic [3:0]  OP_SUB    = 4'h1;
  localparam logic [3:0]  OP_AND    = 4'h2;
  localparam logic [3:0]  OP_OR     = 4'h3;
  localparam logic [3:0]  OP_LD     = 4'h4;
  localparam logic [3:0]  OP_ST     = 4'h5;
  localparam logic [3:0]  OP_BEQZ   = 4'h6;
  localparam logic [3:0]  OP_LI     = 4'h7;
  localparam logic [3:0]  OP_NOP    = 4'h8;
  localparam logic [3:0]  OP_HALT   = 4'hf;
  localparam logic [15:0] NOP_INSTR = 16'h8000;

  function automatic logic is_alu(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    return is_alu(op) || op == OP_LD || op == OP_LI;
  endfunction

  // ST and BEQZ consume rd as a source operand.
  function automatic logic reads_reg(input logic [15:0] ins, input logic [3:0] r);
    logic [3:0] op;
    op = ins[15:12];
    if (is_alu(op)) return (ins[7:4] == r) || (ins[3:0] == r);
    if (op == OP_ST || op == OP_BEQZ) return ins[11:8] == r;
    return 1'b0;
  endfunction

  logic [DW-1:0] rf [16];
  logic [15:0]   ifid_instr, idex_instr;
  logic [DW-1:0] idex_a, idex_b, idex_d;
  logic [3:0]    exmem_op, exmem_rd, memwb_op, memwb_rd;
  logic [DW-1:0] exmem_res, memwb_res;
  logic [2:0]    exmem_flag, memwb_flag;
  logic [AW-1:0] exmem_addr;

  logic [3:0]    id_op, idex_op, idex_rd;
  logic          wb_we, id_stall, halt_pipe, ex_taken;
  logic [DW-1:0] id_a, id_b, id_d, ex_a, ex_b, ex_d, ex_res;
  logic [DW:0]   ex_sum;
  logic [2:0]    ex_flag;
  logic [AW-1:0] ex_target;

  assign id_op   = ifid_instr[15:12];
  assign idex_op = idex_instr[15:12];
  assign idex_rd = idex_instr[11:8];
  assign wb_we   = writes_reg(memwb_op);

  // Register reads see the write retiring in WB this same cycle.
  assign id_a = (wb_we && memwb_rd == ifid_instr[7:4])  ? memwb_res : rf[ifid_instr[7:4]];
  assign id_b = (wb_we && memwb_rd == ifid_instr[3:0])  ? memwb_res : rf[ifid_instr[3:0]];
  assign id_d = (wb_we && memwb_rd == ifid_instr[11:8]) ? memwb_res : rf[ifid_instr[11:8]];

`ifdef TISC_FWD_EN
  assign id_stall = (idex_op == OP_LD) && reads_reg(ifid_instr, idex_rd);
`else
  assign id_stall = (writes_reg(idex_op)  && reads_reg(ifid_instr, idex_rd))
                 || (writes_reg(exmem_op) && reads_reg(ifid_instr, exmem_rd))
                 || (wb_we                && reads_reg(ifid_instr, memwb_rd));
`endif

  assign halt_pipe = (id_op == OP_HALT) || (idex_op == OP_HALT) || (exmem_op == OP_HALT);

`ifdef TISC_FWD_EN
  logic exmem_fwd, memwb_fwd;
  // A load still in MEM never needs forwarding: the interlock keeps its consumer out of EX.
  assign exmem_fwd = writes_reg(exmem_op) && exmem_op != OP_LD;
  assign memwb_fwd = wb_we;
`endif

  always_comb begin
    ex_a = idex_a;
    ex_b = idex_b;
    ex_d = idex_d;
`ifdef TISC_FWD_EN
    if (memwb_fwd && memwb_rd == idex_instr[7:4])  ex_a = memwb_res;
    if (memwb_fwd && memwb_rd == idex_instr[3:0])  ex_b = memwb_res;
    if (memwb_fwd && memwb_rd == idex_instr[11:8]) ex_d = memwb_res;
    if (exmem_fwd && exmem_rd == idex_instr[7:4])  ex_a = exmem_res;
    if (exmem_fwd && exmem_rd == idex_instr[3:0])  ex_b = exmem_res;
    if (exmem_fwd && exmem_rd == idex_instr[11:8]) ex_d = exmem_res;
`endif
  end

  // Bit DW of ex_sum is carry for ADD and borrow for SUB.
  always_comb begin
    ex_sum = '0;
    case (idex_op)
      OP_ADD:  ex_sum = {1'b0, ex_a} + {1'b0, ex_b};
      OP_SUB:  ex_sum = {1'b0, ex_a} - {1'b0, ex_b};
      OP_AND:  ex_sum = {1'b0, ex_a & ex_b};
      OP_OR:   ex_sum = {1'b0, ex_a | ex_b};
      OP_LI:   ex_sum = {1'b0, DW'(idex_instr[7:0])};
      OP_ST:   ex_sum = {1'b0, ex_d};
      default: ex_sum = '0;
    endcase
  end

  assign ex_res    = ex_sum[DW-1:0];
  assign ex_flag   = {ex_res[DW-1], ex_sum[DW], ex_res == '0};
  assign ex_taken  = (idex_op == OP_BEQZ) && (ex_d == '0);
  assign ex_target = AW'(idex_instr[7:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      ifid_instr <= NOP_INSTR;
      idex_instr <= NOP_INSTR;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_d     <= '0;
      exmem_op   <= OP_NOP;
      exmem_rd   <= '0;
      exmem_res  <= '0;
      exmem_flag <= '0;
      exmem_addr <= '0;
      memwb_op   <= OP_NOP;
      memwb_rd   <= '0;
      memwb_res  <= '0;
      memwb_flag <= '0;
      flag       <= '0;
    end else if (!halted) begin
      if (ex_taken) begin
        pc         <= ex_target;
        ifid_instr <= NOP_INSTR;
        idex_instr <= NOP_INSTR;
      end else if (id_stall) begin
        idex_instr <= NOP_INSTR;
      end else if (halt_pipe) begin
        ifid_instr <= NOP_INSTR;
        idex_instr <= ifid_instr;
      end else begin
        pc         <= pc + AW'(1);
        ifid_instr <= instr;
        idex_instr <= ifid_instr;
      end
      idex_a     <= id_a;
      idex_b     <= id_b;
      idex_d     <= id_d;
      exmem_op   <= idex_op;
      exmem_rd   <= idex_rd;
      exmem_res  <= ex_res;
      exmem_flag <= ex_flag;
      exmem_addr <= AW'(idex_instr[7:0]);
      memwb_op   <= exmem_op;
      memwb_rd   <= exmem_rd;
      memwb_res  <= (exmem_op == OP_LD) ? dmem_rdata : exmem_res;
      memwb_flag <= exmem_flag;
      if (is_alu(memwb_op)) flag <= memwb_flag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[memwb_rd] <= memwb_res;
    end
  end

  assign dmem_addr  = exmem_addr;
  assign dmem_wdata = exmem_res;
  assign dmem_we    = (exmem_op == OP_ST);
  assign halted     = (memwb_op == OP_HALT);

endmodule

// File: tb/tb_tisc_pipe_core.sv
// tb/tb_tisc_pipe_core.sv - directed bench for tisc_pipe_core (DW=8/AW=8 and DW=16/AW=10)
module tb_tisc_pipe_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, mem_clr;

  logic [7:0]  pc8, daddr8, wdata8, rdata8;
  logic [15:0] instr8;
  logic        we8, halted8;
  logic [2:0]  flag8;
  logic [9:0]  pc16, daddr16;
  logic [15:0] instr16, wdata16, rdata16;
  logic        we16, halted16;
  logic [2:0]  flag16;

  logic [15:0] prog8  [256];
  logic [7:0]  mem8   [256];
  logic [15:0] prog16 [1024];
  logic [15:0] mem16  [1024];

  assign instr8  = prog8[pc8];
  assign rdata8  = mem8[daddr8];
  assign instr16 = prog16[pc16];
  assign rdata16 = mem16[daddr16];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++)  mem8[i]  <= 8'haa;
      for (int i = 0; i < 1024; i++) mem16[i] <= 16'haaaa;
    end else begin
      if (we8)  mem8[daddr8]   <= wdata8;
      if (we16) mem16[daddr16] <= wdata16;
    end
  end

  tisc_pipe_core #(.DW(8), .AW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .pc(pc8), .instr(instr8),
    .dmem_addr(daddr8), .dmem_wdata(wdata8), .dmem_we(we8), .dmem_rdata(rdata8),
    .flag(flag8), .halted(halted8)
  );

  tisc_pipe_core #(.DW(16), .AW(10)) dut16 (
    .clk(clk), .rst_n(rst_n), .pc(pc16), .instr(instr16),
    .dmem_addr(daddr16), .dmem_wdata(wdata16), .dmem_we(we16), .dmem_rdata(rdata16),
    .flag(flag16), .halted(halted16)
  );

`ifdef TISC_FWD_EN
  localparam int C1 = 10, C2 = 10, C3T = 9, C3N = 8;
`else
  localparam int C1 = 15, C2 = 18, C3T = 12, C3N = 14;
`endif

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    mem_clr = 1'b0;
  endtask

  task automatic clear_prog8();
    for (int i = 0; i < 256; i++) prog8[i] = 16'h8000;
  endtask

  int         cyc_halt, cyc_fetch, we_cnt, we_late;
  logic [7:0] we_addr0, we_data0, pc_at_halt;

  // Counts edges from reset release until halted, then idles 5 more cycles.
  task automatic run8(input int budget);
    int c;
    c = 0;
    cyc_halt = -1; cyc_fetch = -1; we_cnt = 0; we_late = 0;
    we_addr0 = '0; we_data0 = '0;
    do_reset();
    forever begin
      if (instr8[15:12] == 4'hf && !halted8) cyc_fetch = c;
      if (we8) begin
        if (we_cnt == 0) begin
          we_addr0 = daddr8;
          we_data0 = wdata8;
        end
        we_cnt++;
      end
      if (halted8) begin
        cyc_halt = c;
        break;
      end
      if (c == budget) break;
      @(posedge clk);
      c++;
      @(negedge clk);
    end
    pc_at_halt = pc8;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (we8) we_late++;
    end
  endtask

  initial begin
    int c16;
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    clear_prog8();
    for (int i = 0; i < 1024; i++) prog16[i] = 16'h8000;
    prog16[0] = 16'h6708;
    prog16[1] = 16'h725a;
    prog16[2] = 16'h5252;
    prog16[3] = 16'hf000;
    prog16[8] = 16'h71ff;
    for (int i = 9; i <= 16; i++) prog16[i] = 16'h0111;
    prog16[17] = 16'h5150;
    prog16[18] = 16'h0111;
    prog16[19] = 16'h5151;
    prog16[20] = 16'h7701;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", pc8, 8'h00);
    check("rst_we", we8, 1'b0);
    check("rst_addr", daddr8, 8'h00);
    check("rst_wdata", wdata8, 8'h00);
    check("rst_flag", flag8, 3'b000);
    check("rst_halted", halted8, 1'b0);
    check("rst_pc16", pc16, 10'h000);
    check("rst_halted16", halted16, 1'b0);

    // ALU chain with forwarding, then ST, ST, HALT
    clear_prog8();
    prog8[0] = 16'h7105; prog8[1] = 16'h7203; prog8[2] = 16'h0312; prog8[3] = 16'h1421;
    prog8[4] = 16'h5340; prog8[5] = 16'h5441; prog8[6] = 16'hf000;
    run8(100);
    check("s1_r3", mem8[8'h40], 8'h08);
    check("s1_r4", mem8[8'h41], 8'hfe);
    check("s1_flag", flag8, 3'b110);
    check("s1_cycles", cyc_halt, C1);
    check("s1_we_cnt", we_cnt, 2);
    check("s1_halt_lat", cyc_halt - cyc_fetch, 4);
    check("s1_pc_halt", pc_at_halt, 8'h07);
    check("s1_we_late", we_late, 0);
    check("s1_pc_frozen", pc8, 8'h07);
    #2 rst_n = 1'b0;
    #1;
    check("arst_halted", halted8, 1'b0);
    check("arst_pc", pc8, 8'h00);
    check("arst_flag", flag8, 3'b000);
    check("arst_we", we8, 1'b0);

    // Store, load-use, dependent ADD
    clear_prog8();
    prog8[0] = 16'h7107; prog8[1] = 16'h5120; prog8[2] = 16'h4220; prog8[3] = 16'h0322;
    prog8[4] = 16'h5321; prog8[5] = 16'hf000;
    run8(100);
    check("s2_ld_st", mem8[8'h20], 8'h07);
    check("s2_r3", mem8[8'h21], 8'h0e);
    check("s2_we_addr", we_addr0, 8'h20);
    check("s2_we_data", we_data0, 8'h07);
    check("s2_we_cnt", we_cnt, 2);
    check("s2_cycles", cyc_halt, C2);
    check("s2_flag", flag8, 3'b000);

    // Taken branch skips LI r6 and lands at 0x10
    clear_prog8();
    prog8[0] = 16'h7500; prog8[1] = 16'h6510; prog8[2] = 16'h7601; prog8[3] = 16'h5630;
    prog8[4] = 16'hf000; prog8[16] = 16'h5631; prog8[17] = 16'hf000;
    run8(100);
    check("s3t_r6", mem8[8'h31], 8'h00);
    check("s3t_skip", mem8[8'h30], 8'haa);
    check("s3t_cycles", cyc_halt, C3T);
    check("s3t_we_cnt", we_cnt, 1);

    // Same program, branch not taken
    prog8[0] = 16'h7501;
    run8(100);
    check("s3n_r6", mem8[8'h30], 8'h01);
    check("s3n_skip", mem8[8'h31], 8'haa);
    check("s3n_cycles", cyc_halt, C3N);

    // 16-bit datapath: add chain, then PC wrap past 0x3ff
    do_reset();
    c16 = -1;
    for (int i = 0; i < 3000; i++) begin
      if (halted16) begin
        c16 = i;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("w_halted", c16 >= 0, 1'b1);
    check("w_ff00", mem16[10'h050], 16'hff00);
    check("w_fe00", mem16[10'h051], 16'hfe00);
    check("w_wrap", mem16[10'h052], 16'h005a);
    check("w_flag", flag16, 3'b110);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
